// File: rtl/vec_centered_lift_pkg.sv
// Shared types and constants for the residue datapath and the centered lift.
//   word_t      : one residue word, nominally in [0, Q)
//   vec_t       : N_SLOTS_L residue words
//   wide_word_t : one signed output slot, WW_BITS_L wide
//   wide_vec_t  : N_SLOTS_L signed output slots
package vec_centered_lift_pkg;

    localparam int N_SLOTS_L    = 16;
    localparam int W_BITS_L     = 12;
    localparam int WW_BITS_L    = 2 * W_BITS_L;
    localparam int Q_MOD_L      = 3329;
    localparam int LIFT_LANES_L = 4;
    localparam int Q_HALF_L     = (Q_MOD_L - 1) / 2;

    typedef logic [W_BITS_L-1:0]         word_t;
    typedef word_t [N_SLOTS_L-1:0]       vec_t;
    typedef logic signed [WW_BITS_L-1:0] wide_word_t;
    typedef wide_word_t [N_SLOTS_L-1:0]  wide_vec_t;

    localparam word_t Q_WORD    = word_t'(Q_MOD_L);
    localparam word_t HALF_WORD = word_t'(Q_HALF_L);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lift_state_e;

endpackage

// File: rtl/vec_centered_lift_if.sv
// Handshake bundle for vec_centered_lift.
//   in_valid/in_ready/in_vec       : residue vector from the producer
//   out_valid/out_ready/out_vec    : signed centered vector to the consumer
//   range_err                      : a slot of the presented vector was >= Q
// slave  : the lift block
// master : the surrounding datapath (producer and consumer side)
interface vec_centered_lift_if;
    import vec_centered_lift_pkg::*;

    logic      in_valid;
    logic      in_ready;
    vec_t      in_vec;
    logic      out_valid;
    logic      out_ready;
    wide_vec_t out_vec;
    logic      range_err;

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_vec,
        output range_err
    );

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_vec,
        input  range_err
    );

endinterface

// File: rtl/vec_centered_lift_lane.sv
// Combinational centered lift of a single residue word.
//   x   : residue word
//   y   : signed representative, x when x <= HALF, otherwise x - Q
//   oor : x >= Q (still lifted by the same rule, just flagged)
module centered_lift_lane
    import vec_centered_lift_pkg::*;
(
    input  word_t      x,
    output wide_word_t y,
    output logic       oor
);

    logic [WW_BITS_L-1:0] x_ext;
    logic [WW_BITS_L-1:0] q_ext;

    // Both operands zero-extended so the wide subtraction yields the
    // correct two's-complement result for any x, including x >= Q.
    assign x_ext = {{(WW_BITS_L-W_BITS_L){1'b0}}, x};
    assign q_ext = WW_BITS_L'(Q_MOD_L);

    assign oor = (x >= Q_WORD);
    assign y   = (x <= HALF_WORD) ? wide_word_t'(x_ext) : wide_word_t'(x_ext - q_ext);

endmodule

// File: rtl/vec_centered_lift.sv
// Centered lift of a residue vector into signed coefficients, LANES slots
// per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of vec_centered_lift_if (in/out handshakes,
//                residue input vector, signed output vector, range_err)
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// BUSY  | lifting group grp_cnt into the output buffer
// DONE  | output vector presented, waiting for out_ready
module vec_centered_lift
    import vec_centered_lift_pkg::*;
#(
    parameter int LANES = LIFT_LANES_L
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_centered_lift_if.slave bus
);

    localparam int GROUPS = N_SLOTS_L / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int IW     = (N_SLOTS_L > 1) ? $clog2(N_SLOTS_L) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

    if (N_SLOTS_L % LANES != 0) begin : g_bad_lanes
        $error("vec_centered_lift: N_SLOTS_L must be a multiple of LANES");
    end
    if (WW_BITS_L <= W_BITS_L + 1) begin : g_bad_width
        $error("vec_centered_lift: WW_BITS_L must exceed W_BITS_L + 1");
    end

    lift_state_e       state;
    logic [GW-1:0]     grp_cnt;
    vec_t              in_buf;
    wide_vec_t         out_vec_r;
    logic              out_valid_r;
    logic              range_err_r;

    logic [IW-1:0]     base;
    word_t [LANES-1:0] grp_words;
    wide_word_t        lane_y   [LANES];
    logic [LANES-1:0]  lane_oor;

    assign base      = IW'(grp_cnt) * IW'(LANES);
    assign grp_words = in_buf[base +: LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        centered_lift_lane u_lane (
            .x   (grp_words[l]),
            .y   (lane_y[l]),
            .oor (lane_oor[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grp_cnt     <= '0;
            in_buf      <= '0;
            out_vec_r   <= '0;
            out_valid_r <= 1'b0;
            range_err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_buf      <= bus.in_vec;
                        range_err_r <= 1'b0;
                        grp_cnt     <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        out_vec_r[base + IW'(l)] <= lane_y[l];
                    end
                    range_err_r <= range_err_r | (|lane_oor);
                    if (grp_cnt == LAST_GRP) begin
                        grp_cnt     <= '0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        grp_cnt <= grp_cnt + GW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.out_vec   = out_vec_r;
    assign bus.range_err = range_err_r;

endmodule
